// File: rtl/regfile_sb.sv
// Register file with two registered read ports, one write port and a per-register busy scoreboard.
// Optional macro REGFILE_BYPASS_EN: forwards same-edge write data and write-release to the read side.
module regfile_sb #(
    parameter int DATA_W  = 10,
    parameter int ADDR_W  = 3,
    parameter int R0_ZERO = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rf,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic              rd_valid,
    output logic              busy1,
    output logic              busy2,
    input  logic              wf,
    input  logic [ADDR_W-1:0] ws,
    input  logic [DATA_W-1:0] wd,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic              rsv_err
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [DATA_W-1:0] rd1_q, rd1_d, rd2_q, rd2_d;
    logic              rd_valid_q, rd_valid_d;
    logic              rsv_err_q, rsv_err_d;

    logic wr_go, rsv_go;
    logic r1_zero, r2_zero;

    // Writes and reservations aimed at a hardwired-zero r0 are dropped outright.
    always_comb begin
        wr_go   = wf && !((R0_ZERO != 0) && (ws == '0));
        rsv_go  = rsv_en && !((R0_ZERO != 0) && (rsv_addr == '0));
        r1_zero = (R0_ZERO != 0) && (rs1 == '0);
        r2_zero = (R0_ZERO != 0) && (rs2 == '0);
    end

    always_comb begin
        mem_d = mem_q;
        if (wr_go) begin
            mem_d[ws] = wd;
        end
    end

    // Reservation is applied after the release so a same-address reserve wins.
    always_comb begin
        busy_d = busy_q;
        if (wr_go) begin
            busy_d[ws] = 1'b0;
        end
        if (rsv_go) begin
            busy_d[rsv_addr] = 1'b1;
        end
        rsv_err_d = rsv_go && busy_q[rsv_addr];
    end

    always_comb begin
        rd1_d      = rd1_q;
        rd2_d      = rd2_q;
        rd_valid_d = rf;
        if (rf) begin
            rd1_d = r1_zero ? '0 : mem_q[rs1];
            rd2_d = r2_zero ? '0 : mem_q[rs2];
`ifdef REGFILE_BYPASS_EN
            if (wr_go && (ws == rs1)) begin
                rd1_d = wd;
            end
            if (wr_go && (ws == rs2)) begin
                rd2_d = wd;
            end
`endif
        end
    end

    always_comb begin
        busy1 = busy_q[rs1];
        busy2 = busy_q[rs2];
`ifdef REGFILE_BYPASS_EN
        // A retiring producer frees its register now unless a new one claims it this cycle.
        if (wr_go && (ws == rs1) && !(rsv_go && (rsv_addr == rs1))) begin
            busy1 = 1'b0;
        end
        if (wr_go && (ws == rs2) && !(rsv_go && (rsv_addr == rs2))) begin
            busy2 = 1'b0;
        end
`endif
        if (r1_zero) begin
            busy1 = 1'b0;
        end
        if (r2_zero) begin
            busy2 = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            busy_q     <= '0;
            rd1_q      <= '0;
            rd2_q      <= '0;
            rd_valid_q <= 1'b0;
            rsv_err_q  <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            busy_q     <= busy_d;
            rd1_q      <= rd1_d;
            rd2_q      <= rd2_d;
            rd_valid_q <= rd_valid_d;
            rsv_err_q  <= rsv_err_d;
        end
    end

    assign rd1      = rd1_q;
    assign rd2      = rd2_q;
    assign rd_valid = rd_valid_q;
    assign rsv_err  = rsv_err_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb (default parameters); honours REGFILE_BYPASS_EN.
module tb_regfile_sb;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rf;
    logic [2:0] rs1, rs2;
    logic [9:0] rd1, rd2;
    logic       rd_valid;
    logic       busy1, busy2;
    logic       wf;
    logic [2:0] ws;
    logic [9:0] wd;
    logic       rsv_en;
    logic [2:0] rsv_addr;
    logic       rsv_err;

    int n_cmp = 0;
    int n_err = 0;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    regfile_sb #(.DATA_W(10), .ADDR_W(3), .R0_ZERO(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .rf(rf), .rs1(rs1), .rs2(rs2),
        .rd1(rd1), .rd2(rd2), .rd_valid(rd_valid),
        .busy1(busy1), .busy2(busy2),
        .wf(wf), .ws(ws), .wd(wd),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_err(rsv_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; rf = 1'b0; rs1 = 3'd0; rs2 = 3'd0;
        wf = 1'b0; ws = 3'd0; wd = 10'h0; rsv_en = 1'b0; rsv_addr = 3'd0;
        #23;
        chk("reset_rd1", rd1, 0);
        chk("reset_rd2", rd2, 0);
        chk("reset_rd_valid", rd_valid, 0);
        chk("reset_rsv_err", rsv_err, 0);
        rs1 = 3'd5; rs2 = 3'd6;
        #1;
        chk("reset_busy1", busy1, 0);
        chk("reset_busy2", busy2, 0);
        rst_n = 1'b1;
        tick();

        // Cold read
        rf = 1'b1; rs1 = 3'd3; rs2 = 3'd7;
        tick();
        rf = 1'b0;
        chk("cold_rd1", rd1, 0);
        chk("cold_rd2", rd2, 0);
        chk("cold_valid", rd_valid, 1);
        tick();
        chk("cold_valid_drop", rd_valid, 0);

        // Write then read
        wf = 1'b1; ws = 3'd5; wd = 10'h2A5;
        tick();
        wf = 1'b0; rf = 1'b1; rs1 = 3'd5; rs2 = 3'd3;
        tick();
        rf = 1'b0;
        chk("wr5_rd1", rd1, 10'h2A5);
        chk("wr5_rd2", rd2, 10'h000);
        chk("wr5_valid", rd_valid, 1);
        tick();
        chk("hold_rd1", rd1, 10'h2A5);
        chk("hold_valid", rd_valid, 0);

        // r0 ignores writes
        wf = 1'b1; ws = 3'd0; wd = 10'h3FF;
        tick();
        wf = 1'b0; rf = 1'b1; rs1 = 3'd0; rs2 = 3'd5;
        tick();
        rf = 1'b0;
        chk("r0_rd1", rd1, 0);
        chk("r0_rd2", rd2, 10'h2A5);

        // Same-edge write/read of r4
        wf = 1'b1; ws = 3'd4; wd = 10'h001;
        tick();
        wd = 10'h155; rf = 1'b1; rs1 = 3'd4; rs2 = 3'd4;
        tick();
        wf = 1'b0;
        chk("same_edge_rd1", rd1, BYP ? 10'h155 : 10'h001);
        chk("same_edge_rd2", rd2, BYP ? 10'h155 : 10'h001);
        tick();
        rf = 1'b0;
        chk("after_edge_rd1", rd1, 10'h155);

        // Scoreboard on r2
        rsv_en = 1'b1; rsv_addr = 3'd2;
        tick();
        chk("rsv2_err_first", rsv_err, 0);
        rs1 = 3'd2; rs2 = 3'd3;
        #1;
        chk("rsv2_busy1", busy1, 1);
        chk("rsv2_busy2", busy2, 0);
        tick();
        rsv_en = 1'b0;
        chk("rsv2_err_again", rsv_err, 1);
        tick();
        chk("rsv2_err_one_cycle", rsv_err, 0);
        wf = 1'b1; ws = 3'd2; wd = 10'h0C3;
        #1;
        chk("wr2_busy1_comb", busy1, BYP ? 0 : 1);
        tick();
        wf = 1'b0;
        #1;
        chk("wr2_busy1_released", busy1, 0);

        // r0 reservations are ignored
        rsv_en = 1'b1; rsv_addr = 3'd0;
        tick();
        tick();
        rsv_en = 1'b0;
        rs1 = 3'd0;
        #1;
        chk("rsv0_err", rsv_err, 0);
        chk("rsv0_busy1", busy1, 0);

        // Reserve beats write on r6
        rsv_en = 1'b1; rsv_addr = 3'd6;
        tick();
        wf = 1'b1; ws = 3'd6; wd = 10'h0AB; rs1 = 3'd6;
        #1;
        chk("r6_busy1_pre", busy1, 1);
        tick();
        rsv_en = 1'b0; wf = 1'b0;
        #1;
        chk("r6_rsv_err", rsv_err, 1);
        chk("r6_busy1_post", busy1, 1);
        rf = 1'b1;
        tick();
        rf = 1'b0;
        chk("r6_data", rd1, 10'h0AB);

        // Asynchronous reset mid-operation
        rsv_en = 1'b1; rsv_addr = 3'd3;
        tick();
        rsv_en = 1'b0; rf = 1'b1; rs1 = 3'd5; rs2 = 3'd4;
        tick();
        rf = 1'b0;
        chk("pre_rst_valid", rd_valid, 1);
        chk("pre_rst_rd1", rd1, 10'h2A5);
        rs1 = 3'd3; rs2 = 3'd6;
        #1;
        chk("pre_rst_busy1", busy1, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", rd_valid, 0);
        chk("async_rst_rd1", rd1, 0);
        chk("async_rst_rd2", rd2, 0);
        chk("async_rst_busy1", busy1, 0);
        chk("async_rst_busy2", busy2, 0);
        #4;
        rst_n = 1'b1;
        rf = 1'b1; rs1 = 3'd5; rs2 = 3'd6;
        tick();
        rf = 1'b0;
        chk("post_rst_rd1", rd1, 0);
        chk("post_rst_rd2", rd2, 0);
        chk("post_rst_valid", rd_valid, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
